// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle for univ_shift_reg (WIDTH-bit register, $clog2(WIDTH)-bit count).
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);
  logic             clear;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             rotate;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic [CNT_W-1:0] cnt;
  logic             word_done;
  modport master (
    output clear, en, mode, d, sin_r, sin_l, rotate,
    input  q, so_r, so_l, cnt, word_done
  );
  modport slave (
    input  clear, en, mode, d, sin_r, sin_l, rotate,
    output q, so_r, so_l, cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold / shift right / shift left / parallel load register with shift count and word-done pulse.
// Define USR_ROTATE_EN to honour the rotate input (circular shifts); otherwise rotate is ignored.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  univ_shift_reg_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt;
  logic             word_done;
  logic             shift;
  logic             last;
  logic             in_r;
  logic             in_l;
`ifdef USR_ROTATE_EN
  assign in_r = bus.rotate ? q[0] : bus.sin_r;
  assign in_l = bus.rotate ? q[WIDTH-1] : bus.sin_l;
`else
  assign in_r = bus.sin_r;
  assign in_l = bus.sin_l;
`endif
  assign shift = bus.en && (bus.mode == 2'b01 || bus.mode == 2'b10);
  assign last  = cnt == CNT_W'(WIDTH - 1);
  always_comb
    q_nxt = !bus.en            ? q :
            bus.mode == 2'b01  ? {in_r, q[WIDTH-1:1]} :
            bus.mode == 2'b10  ? {q[WIDTH-2:0], in_l} :
            bus.mode == 2'b11  ? bus.d : q;
  // A load discards the partial count; the wrap to 0 and the pulse share one edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q         <= RESET_VAL;
      cnt       <= '0;
      word_done <= 1'b0;
    end else if (bus.clear) begin
      q         <= RESET_VAL;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      q         <= q_nxt;
      cnt       <= ((bus.en && bus.mode == 2'b11) || (shift && last)) ? '0 : shift ? cnt + 1'b1 : cnt;
      word_done <= shift && last;
    end
  assign bus.q         = q;
  assign bus.so_r      = q[0];
  assign bus.so_l      = q[WIDTH-1];
  assign bus.cnt       = cnt;
  assign bus.word_done = word_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5); honours USR_ROTATE_EN.
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  univ_shift_reg_if #(.WIDTH(8)) bus ();
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] dv,
                       input logic sr, input logic sl, input logic rt);
    bus.en = e; bus.mode = m; bus.d = dv; bus.sin_r = sr; bus.sin_l = sl; bus.rotate = rt;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [7:0] sr_seq;
    logic [7:0] sl_seq;
    int pulses;
    int first;
    int lastp;
    bus.clear = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.d = '0;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.rotate = 1'b0;
    #12;
    check("rst_q", bus.q, 8'hA5);
    check("rst_cnt", bus.cnt, 0);
    check("rst_wd", bus.word_done, 0);
    check("rst_so_r", bus.so_r, 1);
    check("rst_so_l", bus.so_l, 1);
    rst_n = 1'b1;
    drive(1, 2'b11, 8'h3C, 0, 0, 0);
    check("load_q", bus.q, 8'h3C);
    drive(1, 2'b01, 8'h00, 0, 0, 0);
    check("shift1_cnt", bus.cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_q", bus.q, 8'hA5);
    check("async_cnt", bus.cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 2'b11, 8'h3C, 0, 0, 0);
    drive(1, 2'b01, 8'h00, 0, 0, 0);
    bus.clear = 1'b1;
    drive(1, 2'b11, 8'hFF, 0, 0, 0);
    bus.clear = 1'b0;
    check("clear_q", bus.q, 8'hA5);
    check("clear_cnt", bus.cnt, 0);
    drive(1, 2'b11, 8'hB4, 0, 0, 0);
    sr_seq = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser_so_r%0d", i), bus.so_r, sr_seq[i]);
      check($sformatf("ser_cnt%0d", i), bus.cnt, i);
      check($sformatf("ser_wd%0d", i), bus.word_done, 0);
      drive(1, 2'b01, 8'h00, 0, 0, 0);
    end
    check("ser_q", bus.q, 8'h00);
    check("ser_wd", bus.word_done, 1);
    check("ser_cnt", bus.cnt, 0);
    drive(1, 2'b11, 8'h00, 0, 0, 0);
    sl_seq = 8'b1010_0110;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b10, 8'h00, 0, sl_seq[7-i], 0);
      check($sformatf("des_cnt%0d", i), bus.cnt, (i + 1) % 8);
      check($sformatf("des_wd%0d", i), bus.word_done, i == 7);
    end
    check("des_q", bus.q, 8'hA6);
    drive(1, 2'b11, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2'b01, 8'h00, 1, 0, 0);
    check("gate_q0", bus.q, 8'hE0);
    check("gate_cnt0", bus.cnt, 3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b01, 8'h00, 1, 0, 0);
      check($sformatf("gate_q%0d", i + 1), bus.q, 8'hE0);
      check($sformatf("gate_cnt%0d", i + 1), bus.cnt, 3);
      check($sformatf("gate_wd%0d", i + 1), bus.word_done, 0);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b01, 8'h00, 1, 0, 0);
      pulses += int'(bus.word_done);
    end
    check("resume_pulses", pulses, 1);
    check("resume_q", bus.q, 8'hFF);
    drive(1, 2'b00, 8'h00, 0, 0, 0);
    check("hold_q", bus.q, 8'hFF);
    check("hold_wd", bus.word_done, 0);
    check("hold_cnt", bus.cnt, 0);
    drive(1, 2'b01, 8'h00, 0, 0, 0);
    drive(1, 2'b10, 8'h00, 0, 0, 0);
    check("mid_cnt", bus.cnt, 2);
    drive(1, 2'b11, 8'h5A, 0, 0, 0);
    check("midload_q", bus.q, 8'h5A);
    check("midload_cnt", bus.cnt, 0);
    check("midload_wd", bus.word_done, 0);
    drive(1, 2'b11, 8'h00, 0, 0, 0);
    pulses = 0; first = -1; lastp = -1;
    for (int i = 0; i < 24; i++) begin
      drive(1, (i % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 0, 1, 0);
      if (bus.word_done) begin
        pulses++;
        if (first < 0) first = i;
        lastp = i;
      end
    end
    check("stream_pulses", pulses, 3);
    check("stream_first", first, 7);
    check("stream_last", lastp, 23);
    drive(1, 2'b11, 8'h81, 0, 0, 0);
    drive(1, 2'b01, 8'h00, 0, 0, 1);
`ifdef USR_ROTATE_EN
    check("rot_r", bus.q, 8'hC0);
`else
    check("rot_r", bus.q, 8'h40);
`endif
    drive(1, 2'b10, 8'h00, 0, 0, 1);
`ifdef USR_ROTATE_EN
    check("rot_l", bus.q, 8'h81);
`else
    check("rot_l", bus.q, 8'h80);
`endif
    check("rot_cnt", bus.cnt, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
